// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges IF/ID/EX stall requests into one nested stall vector,
// sequences multi-cycle EX operations and keeps a saturating count of stalled cycles.
module pipe_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned EXCYC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               ex_start,
    input  logic [EXCYC_W-1:0] ex_cycles,
    input  logic               flush_i,
    input  logic               clr_stat,
    output logic [5:0]         stall_o,
    output logic               flush_o,
    output logic               ex_busy_o,
    output logic               ex_done_o,
    output logic [CNT_W-1:0]   stall_cycles_o
);

    localparam logic StIdle = 1'b0;
    localparam logic StBusy = 1'b1;

    localparam logic [5:0] StallEx = 6'b001111;
    localparam logic [5:0] StallId = 6'b000111;
    localparam logic [5:0] StallIf = 6'b000011;

    localparam logic [EXCYC_W-1:0] CycOne  = EXCYC_W'(1);
    localparam logic [CNT_W-1:0]   StatMax = {CNT_W{1'b1}};

    logic               state_q, state_d;
    logic [EXCYC_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   stat_q, stat_d;

    logic               accept;
    logic               ex_req;
    logic [EXCYC_W-1:0] n_cyc;

    // The held instruction keeps ex_start high, so ignore it while busy and in the done cycle.
    assign accept = ex_start & (state_q == StIdle) & ~done_q & ~flush_i;
    assign n_cyc  = (ex_cycles == '0) ? CycOne : ex_cycles;
    assign ex_req = accept | (state_q == StBusy);

    always_comb begin
        stall_o = 6'b000000;
        if (flush_i) begin
            stall_o = 6'b000000;
        end else if (ex_req) begin
            stall_o = StallEx;
        end else if (stallreq_id) begin
            stall_o = StallId;
        end else if (stallreq_if) begin
            stall_o = StallIf;
        end
    end

    assign flush_o        = flush_i;
    assign ex_busy_o      = (state_q == StBusy);
    assign ex_done_o      = done_q;
    assign stall_cycles_o = stat_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (accept) begin
            if (n_cyc == CycOne) begin
                done_d = 1'b1;
            end else begin
                state_d = StBusy;
                cnt_d   = n_cyc - CycOne;
            end
        end else if (state_q == StBusy) begin
            if (cnt_q == CycOne) begin
                state_d = StIdle;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - CycOne;
            end
        end
    end

    always_comb begin
        stat_d = stat_q;
        if (clr_stat) begin
            stat_d = '0;
        end else if (stall_o[0] && (stat_q != StatMax)) begin
            stat_d = stat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            stat_q  <= stat_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: table-driven single-cycle vectors plus
// hand-written sequences for reset, flush and statistics corner cases.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stallreq_if = 1'b0;
    logic       stallreq_id = 1'b0;
    logic       ex_start = 1'b0;
    logic [5:0] ex_cycles = 6'd0;
    logic       flush_i = 1'b0;
    logic       clr_stat = 1'b0;
    logic [5:0] stall_o;
    logic       flush_o;
    logic       ex_busy_o;
    logic       ex_done_o;
    logic [3:0] stall_cycles_o;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .CNT_W  (4),
        .EXCYC_W(6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .ex_start      (ex_start),
        .ex_cycles     (ex_cycles),
        .flush_i       (flush_i),
        .clr_stat      (clr_stat),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .ex_busy_o     (ex_busy_o),
        .ex_done_o     (ex_done_o),
        .stall_cycles_o(stall_cycles_o)
    );

    typedef struct {
        logic       s_if;
        logic       s_id;
        logic       start;
        logic [5:0] cyc;
        logic       flush;
        logic [5:0] e_stall;
        logic       e_flush;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s_if, input logic s_id, input logic start,
                                input logic [5:0] cyc, input logic flush,
                                input logic [5:0] e_stall, input logic e_flush,
                                input logic e_busy, input logic e_done);
        vec_t v;
        v.s_if = s_if; v.s_id = s_id; v.start = start; v.cyc = cyc; v.flush = flush;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic i_if, input logic i_id, input logic i_st,
                         input logic [5:0] cyc, input logic fl, input logic cl);
        stallreq_if = i_if;
        stallreq_id = i_id;
        ex_start    = i_st;
        ex_cycles   = cyc;
        flush_i     = fl;
        clr_stat    = cl;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 6'd0, 0, 0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        next_cycle();
    endtask

    initial begin
        // ex_cycles=5 held high: 5 stalled cycles, done in the 6th, no re-trigger there.
        vecs.push_back(mk(0, 0, 1, 6'd5, 0, 6'b001111, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 6'd5, 0, 6'b001111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 6'd5, 0, 6'b001111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 6'd5, 0, 6'b001111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 6'd5, 0, 6'b001111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 6'd5, 0, 6'b000000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 6'd5, 0, 6'b000000, 0, 0, 0));
        // ex_cycles=0 behaves as 1.
        vecs.push_back(mk(0, 0, 1, 6'd0, 0, 6'b001111, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0));
        // ex_cycles=1.
        vecs.push_back(mk(0, 0, 1, 6'd1, 0, 6'b001111, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 6'd1, 0, 6'b000000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 6'd1, 0, 6'b000000, 0, 0, 0));
        // Nested priority: EX > ID > IF.
        vecs.push_back(mk(1, 1, 1, 6'd1, 0, 6'b001111, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 6'd1, 0, 6'b000111, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 6'd1, 0, 6'b000011, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 6'd1, 0, 6'b000111, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 6'd1, 0, 6'b000000, 0, 0, 0));
        // Flush overrides requests; flush with a new ex_start does not accept.
        vecs.push_back(mk(1, 1, 0, 6'd1, 1, 6'b000000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 6'd3, 1, 6'b000000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 6'd3, 0, 6'b000000, 0, 0, 0));

        // Reset state.
        #2;
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_flush", 32'(flush_o), 32'h0);
        chk("rst_busy", 32'(ex_busy_o), 32'h0);
        chk("rst_done", 32'(ex_done_o), 32'h0);
        chk("rst_stat", 32'(stall_cycles_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].s_if, vecs[i].s_id, vecs[i].start, vecs[i].cyc, vecs[i].flush, 0);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush_o), 32'(vecs[i].e_flush));
            chk($sformatf("vec%0d_busy", i), 32'(ex_busy_o), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_done", i), 32'(ex_done_o), 32'(vecs[i].e_done));
            next_cycle();
        end

        // Reset mid-BUSY at the 4th stalled cycle of a 10-cycle op.
        drive(0, 0, 1, 6'd10, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rb_stall%0d", c), 32'(stall_o), 32'h0f);
            next_cycle();
        end
        #1;
        chk("rb_stall3", 32'(stall_o), 32'h0f);
        chk("rb_busy3", 32'(ex_busy_o), 32'h1);
        ex_start = 1'b0;
        rst = 1'b1;
        #1;
        chk("rb_now_stall", 32'(stall_o), 32'h0);
        chk("rb_now_busy", 32'(ex_busy_o), 32'h0);
        chk("rb_now_done", 32'(ex_done_o), 32'h0);
        chk("rb_now_flush", 32'(flush_o), 32'h0);
        chk("rb_now_stat", 32'(stall_cycles_o), 32'h0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            chk($sformatf("rb_nodone%0d", c), 32'({ex_busy_o, ex_done_o}), 32'h0);
        end

        // Flush during BUSY with cnt=3 (third cycle of a 5-cycle op).
        drive(0, 0, 1, 6'd5, 0, 0);
        next_cycle();
        next_cycle();
        drive(0, 0, 0, 6'd5, 1, 0);
        #1;
        chk("fl_flush", 32'(flush_o), 32'h1);
        chk("fl_stall", 32'(stall_o), 32'h0);
        next_cycle();
        drive(0, 0, 0, 6'd5, 0, 0);
        #1;
        chk("fl_busy_after", 32'(ex_busy_o), 32'h0);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("fl_nodone%0d", c), 32'(ex_done_o), 32'h0);
            next_cycle();
        end

        // Statistics: saturation and clear priority.
        pulse_reset();
        drive(1, 0, 0, 6'd0, 0, 0);
        for (int c = 0; c < 3; c++) next_cycle();
        chk("st_count3", 32'(stall_cycles_o), 32'd3);
        for (int c = 3; c < 20; c++) next_cycle();
        chk("st_sat", 32'(stall_cycles_o), 32'd15);
        drive(1, 0, 0, 6'd0, 0, 1);
        next_cycle();
        chk("st_clr", 32'(stall_cycles_o), 32'd0);
        drive(1, 0, 0, 6'd0, 0, 0);
        next_cycle();
        chk("st_after_clr", 32'(stall_cycles_o), 32'd1);
        drive(0, 0, 0, 6'd0, 0, 0);
        next_cycle();
        chk("st_hold", 32'(stall_cycles_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. It collects stall requests from fetch (ROM wait), decode (load-use), and execute (multi-cycle HI/LO and divide operations) and drives one 6-bit stall vector to pc_reg, if_id, id_ex, ex_mem and mem_wb. It owns the down-counter that sequences multi-cycle EX operations and signals their completion. It also counts stalled cycles for performance checks.

## Interface
- CNT_W, 16: width of the stall-cycle statistics counter.
- EXCYC_W, 6: width of the EX cycle-count input.

- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stallreq_if  input  1  fetch not ready (ROM wait state); combinational request.
- stallreq_id  input  1  load-use hazard from ID; combinational request.
- ex_start  input  1  EX holds a multi-cycle op; may stay high while the op sits in EX.
- ex_cycles  input  EXCYC_W  number of cycles the op occupies EX; sampled with ex_start; 0 is treated as 1.
- flush_i  input  1  exception/redirect flush request.
- clr_stat  input  1  synchronous clear of stall_cycles_o.
- stall_o  output  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush_o  output  1  flush all pipeline registers this cycle.
- ex_busy_o  output  1  multi-cycle sequencer in BUSY.
- ex_done_o  output  1  one-cycle pulse: the multi-cycle result is valid and EX advances this cycle.
- stall_cycles_o  output  CNT_W  saturating count of cycles with stall_o[0]=1.

## Operation
- States: IDLE, BUSY. Registers: state, cnt (EXCYC_W), done_r, stall_cycles.
- Accept condition: ex_start & IDLE & ~done_r & ~flush_i. ex_start is ignored in BUSY and in the done cycle, because the held instruction keeps ex_start high.
- On accept with N = max(ex_cycles, 1):
  - N=1: stay in IDLE, done_r←1.
  - N>1: go to BUSY, cnt←N−1.
- In BUSY: if cnt==1, go to IDLE and set done_r←1; otherwise cnt←cnt−1.
- done_r clears on the next edge unless it is set again. ex_done_o = done_r.
- Stall request sources:
  - ex_req = accept | BUSY
  - stall_o = 6'b001111 if ex_req, else 6'b000111 if stallreq_id, else 6'b000011 if stallreq_if, else 0.
  - The encodings are nested, so the highest request wins.
- Flush:
  - flush_i forces stall_o=0 and flush_o=1 in the same cycle (combinational).
  - At the edge: state←IDLE, cnt←0, done_r←0. ex_done_o is suppressed.
  - Flush overrides all stall sources.
- Statistics: stall_cycles increments each cycle stall_o[0]=1 and saturates at 2^CNT_W−1.
  - clr_stat has priority over the increment: the counter is 0 after the edge.
- ex_busy_o = (state==BUSY).

## Timing
- stall_o and flush_o are combinational from the registered state and the current inputs. There are no registers in the request path, so a load-use stall takes effect in the same cycle.
- Multi-cycle op with ex_start first high in cycle T:
  - stall_o=001111 during cycles T..T+N−1, exactly N cycles.
  - ex_done_o=1 and stall_o free of EX in cycle T+N.
  - The op leaves EX at the end of T+N.
- Back-to-back multi-cycle ops: the second op's ex_start is accepted no earlier than cycle T+N+1.
- Reset (asynchronous, any time, including mid-BUSY): state=IDLE, cnt=0, done_r=0, stall_cycles=0.
  - Consequently ex_busy_o=0, ex_done_o=0, stall_cycles_o=0.
  - stall_o=0 and flush_o=0 provided the request inputs are low.
- Flush in the final BUSY cycle (cnt==1): flush wins and no ex_done_o pulse follows.
- Flush in the same cycle as a new ex_start: no accept occurs.

## Test plan
- Reset mid-BUSY (ex_cycles=10, assert rst at the 4th stalled cycle) -> all outputs 0 immediately; after release, no ex_done_o pulse occurs.
- ex_start held high with ex_cycles=5 from cycle T -> stall_o=001111 for exactly 5 cycles, ex_done_o=1 in cycle T+5, no re-trigger while ex_start stays high through T+5.
- ex_cycles=0 and ex_cycles=1 -> each gives 1 stalled cycle, then ex_done_o in the next cycle; ex_busy_o never asserts.
- stallreq_if, stallreq_id and ex_start all high in one cycle -> stall_o=001111.
  - Drop ex_start -> stall_o=000111.
  - Drop stallreq_id -> stall_o=000011.
- flush_i during BUSY with cnt=3 -> flush_o=1 and stall_o=0 that cycle; ex_busy_o=0 the next cycle; no ex_done_o.
- Statistics with CNT_W=4:
  - Stall 20 consecutive cycles -> stall_cycles_o saturates at 15.
  - clr_stat together with an active stall -> 0 the next cycle, 1 the cycle after.
